// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues one memory request at a time and
// buffers returned instruction words, with their PCs, in a small
// first-word-fall-through queue. A redirect flushes the queue and restarts
// fetch from a new address. Any response still outstanding at that point is
// squashed rather than pushed.
module fetch_queue #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_inst_start,
    input  logic        mem_inst_ready,
    output logic [31:0] mem_i_addr,
    input  logic [31:0] mem_inst,
    input  logic        mem_inst_valid,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        out_ready
);

    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);

    // IDLE: nothing outstanding, WAIT: live request, DROP: squashed request
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state;
    logic [31:0]        fetch_pc;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [31:0]        pc_buf   [QUEUE_DEPTH];
    logic [31:0]        inst_buf [QUEUE_DEPTH];
    logic               push;
    logic               pop;

    // A request may only go out when nothing is in flight and there is
    // guaranteed room for its response, so a push can never hit a full queue.
    // Held low while reset is asserted.
    assign mem_inst_start = rst_n && (state == IDLE) && mem_inst_ready &&
                            (count < DEPTH_CNT) && !redirect;
    assign mem_i_addr     = fetch_pc;

    assign push      = (state == WAIT) && mem_inst_valid && !redirect;
    assign pop       = out_valid && out_ready && !redirect;

    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? pc_buf[head]   : 32'h0;
    assign out_inst  = out_valid ? inst_buf[head] : 32'h0;

    // Request tracking FSM: at most one request is ever outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_inst_start)
                        state <= WAIT;
                end
                WAIT: begin
                    if (mem_inst_valid)
                        state <= IDLE;
                    else if (redirect)
                        state <= DROP;
                end
                DROP: begin
                    if (mem_inst_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Fetch address: jumps on redirect, otherwise advances by one word per accepted response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_pc <= RESET_PC;
        else if (redirect)
            fetch_pc <= redirect_pc;
        else if (push)
            fetch_pc <= fetch_pc + 32'd4;
    end

    // Queue pointers and occupancy; a redirect empties the queue outright
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (redirect) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (push)
                tail <= tail + PTR_W'(1);
            if (pop)
                head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset because count masks stale contents
    always_ff @(posedge clk) begin
        if (push) begin
            pc_buf[tail]   <= fetch_pc;
            inst_buf[tail] <= mem_inst;
        end
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, giving the number of buffered instruction entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h00000000, giving the first fetch address after reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port mem_inst_start, output, 1 bit: fetch request to the memory interface.
REQ-006 SHALL have port mem_inst_ready, input, 1 bit: the memory interface accepts a request this cycle.
REQ-007 SHALL have port mem_i_addr, output, 32 bits: fetch address; equals fetch_pc at all times.
REQ-008 SHALL have port mem_inst, input, 32 bits: returned instruction word.
REQ-009 SHALL have port mem_inst_valid, input, 1 bit: mem_inst is valid this cycle.
REQ-010 SHALL have port redirect, input, 1 bit: flush the queue and restart fetch.
REQ-011 SHALL have port redirect_pc, input, 32 bits: new fetch address, used as-is with no alignment.
REQ-012 SHALL have port out_valid, output, 1 bit: the queue head is valid.
REQ-013 SHALL have port out_pc, output, 32 bits: PC of the head entry.
REQ-014 SHALL have port out_inst, output, 32 bits: instruction of the head entry.
REQ-015 SHALL have port out_ready, input, 1 bit: the consumer takes the head entry this cycle.

Function
REQ-016 SHALL implement a three-state FSM: IDLE (no request in flight), WAIT (one request in flight), DROP (one squashed request in flight).
REQ-017 SHALL drive mem_inst_start combinationally as 1 only when all hold: state IDLE, mem_inst_ready=1, count<QUEUE_DEPTH, redirect=0.
REQ-018 A request SHALL be accepted on the edge where mem_inst_start=1; that edge moves IDLE->WAIT.
REQ-019 SHALL keep at most one request in flight; no start is issued in WAIT or DROP.
REQ-020 In WAIT with mem_inst_valid=1 and redirect=0: push {fetch_pc, mem_inst} at the tail, set fetch_pc<=fetch_pc+4 (mod 2^32, wraps from FFFFFFFC to 0), and go to IDLE.
REQ-021 In DROP with mem_inst_valid=1: discard mem_inst, leave fetch_pc unchanged, and go to IDLE.
REQ-022 mem_inst_valid in IDLE SHALL be ignored.
REQ-023 On redirect=1: set count<=0, reset head and tail, and set fetch_pc<=redirect_pc.
REQ-024 Next state on redirect=1: WAIT with valid=0 goes to DROP; WAIT with valid=1 discards the data and goes to IDLE; DROP with valid=0 stays DROP; DROP with valid=1 goes to IDLE; IDLE stays IDLE.
REQ-025 SHALL implement the queue as a first-word-fall-through circular buffer with head and tail pointers that wrap modulo QUEUE_DEPTH.
REQ-026 SHALL set out_valid=(count!=0), with out_pc and out_inst taken from the head entry; outputs are 0 when the queue is empty.
REQ-027 A pop SHALL occur when out_valid=1, out_ready=1 and redirect=0.
REQ-028 A simultaneous push and pop SHALL leave count unchanged; a push on a full queue is impossible by REQ-017.
REQ-029 Latency: an entry pushed on edge N SHALL appear on out_valid from cycle N+1 when the queue was empty.
REQ-030 When the queue is full, SHALL hold mem_inst_start=0 until a pop frees an entry, and issue in the cycle after that pop.

Reset
REQ-031 On rst_n=0, immediately and regardless of clk: state<=IDLE, fetch_pc<=RESET_PC, count, head and tail <=0, out_valid=0, mem_inst_start=0.
REQ-032 A response arriving after a reset that occurred mid-request SHALL be ignored, because the state is IDLE.
REQ-033 After rst_n rises, mem_inst_start SHALL assert in the first cycle in which mem_inst_ready=1.

Verification
REQ-034 Streaming: mem_inst_ready=1, valid 1 cycle after each start, out_ready=1, RESET_PC=0 -> out_pc sequence 0,4,8,C with the matching mem_inst values.
REQ-035 Full: out_ready=0, QUEUE_DEPTH=4 -> exactly 4 starts, then mem_inst_start=0; one pop -> exactly one further start.
REQ-036 Redirect in flight: redirect with redirect_pc=0x100 while in WAIT -> DROP; the late valid with data 0xDEADBEEF is discarded; next start has mem_i_addr=0x100 and out_pc=0x100.
REQ-037 Redirect with a simultaneous valid in WAIT -> data is not pushed, state is IDLE, next mem_i_addr=redirect_pc, out_valid=0 the next cycle.
REQ-038 Wrap: redirect_pc=0xFFFFFFFC -> entries have out_pc FFFFFFFC then 00000000; buffer pointers wrap correctly across more than QUEUE_DEPTH pushes.
REQ-039 Async reset asserted between clock edges while in WAIT with 3 entries queued -> out_valid=0 at once; the stale valid is ignored; fetch restarts at RESET_PC.
